pipe_hazard_ctrl: RTL

Central pipeline sequencer for the five-stage core. Each cycle it decides whether the front-end pipeline registers (PC, IF/ID, ID/EX) advance, hold or flush. Inputs are AXI/cache wait conditions, load-use hazards, EX-stage branch redirects and multi-cycle mul/div operations. It also counts stalled and flushed cycles for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Front-end pipeline sequencer: decides advance / hold / flush of PC, IF/ID and ID/EX
// each cycle, sequences multi-cycle mul/div ops and keeps stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             im_busy,
    input  logic             dm_busy,
    input  logic             ld_use_hazard,
    input  logic             branch_taken,
    input  logic             md_start,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MDC_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [MDC_W-1:0] MD_RELOAD = MDC_W'(MD_LAT - 2);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               md_hold;

    // Branch cannot override a running mul/div hold: the op itself still occupies EX.
    assign md_hold = (state_q == MD_BUSY) && (md_cnt_q != '0);

    always_comb begin
        stall         = 1'b0;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        if_flush      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;

        if (rst) begin
            state_d  = RUN;
            md_cnt_d = '0;
        end else if (im_busy || dm_busy) begin
            stall = 1'b1;
        end else if (branch_taken && !md_hold) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            if_flush    = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
        end else if (md_hold) begin
            ex_mem_bubble = 1'b1;
            md_cnt_d      = md_cnt_q - MDC_W'(1);
        end else if ((state_q == RUN) && md_start) begin
            ex_mem_bubble = 1'b1;
            md_cnt_d      = MD_RELOAD;
            state_d       = MD_BUSY;
        end else begin
            // RUN without md_start, or the MD release cycle
            state_d = RUN;
            if (ld_use_hazard) begin
                id_ex_write = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                id_ex_write = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign md_busy   = (state_q == MD_BUSY);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
